// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_hazard_ctrl_pkg;

  // Controller FSM: either free-running or waiting on data memory.
  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMemWait = 1'b1
  } hz_state_e;

  // Register-file address width used across the processor (srcRegDir).
  localparam int unsigned RegDirWDefault = 4;

  // Pipeline control word width and the bubble loaded on a flush.
  localparam int unsigned CtrlW = 17;
  localparam logic [CtrlW-1:0] BubbleCtrl = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction reading the register that a
// load currently in EXE has not yet written back.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_DIR_W = RegDirWDefault
) (
  input  logic [REG_DIR_W-1:0] id_rs_a,
  input  logic [REG_DIR_W-1:0] id_rs_b,
  input  logic                 id_use_a,
  input  logic                 id_use_b,
  input  logic                 exe_valid,
  input  logic                 exe_is_load,
  input  logic [REG_DIR_W-1:0] exe_rd,
  output logic                 load_use
);

  logic match_a;
  logic match_b;

  // Full-width compare; there is no hardwired-zero register to exclude.
  always_comb begin
    match_a  = id_use_a && (id_rs_a == exe_rd);
    match_b  = id_use_b && (id_rs_b == exe_rd);
    load_use = exe_valid && exe_is_load && (match_a || match_b);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: memory-stall FSM, branch/load-use
// resolution, sticky memory-timeout flag and stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_DIR_W   = RegDirWDefault,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_DIR_W-1:0] id_rs_a,
  input  logic [REG_DIR_W-1:0] id_rs_b,
  input  logic                 id_use_a,
  input  logic                 id_use_b,
  input  logic                 exe_valid,
  input  logic                 exe_is_load,
  input  logic [REG_DIR_W-1:0] exe_rd,
  input  logic                 exe_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 hold_if_id,
  output logic                 hold_id_exe,
  output logic                 hold_exe_mem,
  output logic                 hold_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_exe,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  hz_state_e         state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              load_use;
  logic              mem_stall;
  logic              resolve;

  pipe_hazard_ctrl_hazard_detect #(
    .REG_DIR_W (REG_DIR_W)
  ) u_hazard_detect (
    .id_rs_a     (id_rs_a),
    .id_rs_b     (id_rs_b),
    .id_use_a    (id_use_a),
    .id_use_b    (id_use_b),
    .exe_valid   (exe_valid),
    .exe_is_load (exe_is_load),
    .exe_rd      (exe_rd),
    .load_use    (load_use)
  );

  // Memory-stall FSM: decides whether this cycle freezes the whole pipe.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_req && !mem_ready) begin
          mem_stall = 1'b1;
          state_d   = StMemWait;
          wait_d    = WaitW'(1);
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d = StIdle;
          wait_d  = '0;
        end else if (wait_q == WaitW'(MEM_TIMEOUT)) begin
          // Abort: treat the access as complete and flag the error.
          timeout_d = 1'b1;
          state_d   = StIdle;
          wait_d    = '0;
        end else begin
          mem_stall = 1'b1;
          wait_d    = wait_q + WaitW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        wait_d  = '0;
      end
    endcase
  end

  // Output priority: reset, memory stall, taken branch, load-use.
  always_comb begin
    hold_if_id   = 1'b0;
    hold_id_exe  = 1'b0;
    hold_exe_mem = 1'b0;
    hold_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    resolve      = 1'b0;
    if (rst) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (mem_stall) begin
      hold_if_id   = 1'b1;
      hold_id_exe  = 1'b1;
      hold_exe_mem = 1'b1;
      hold_mem_wb  = 1'b1;
    end else begin
      resolve = 1'b1;
    end
    if (resolve) begin
      if (exe_branch_taken) begin
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (load_use) begin
        hold_if_id   = 1'b1;
        flush_id_exe = 1'b1;
      end
    end
  end

  // Saturating count of front-end stall cycles.
  always_comb begin
    stall_d = stall_q;
    if (hold_if_id && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State and counters; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RW  = 4;
  localparam int unsigned TMO = 16;
  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs_a, id_rs_b, exe_rd;
  logic          id_use_a, id_use_b, exe_valid, exe_is_load, exe_branch_taken;
  logic          mem_req, mem_ready;
  logic          hold_if_id, hold_id_exe, hold_exe_mem, hold_mem_wb;
  logic          flush_if_id, flush_id_exe, mem_timeout;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Model state: cycles the outstanding access has waited (0 = none),
  // accumulated stall count and the sticky timeout flag.
  int m_waited = 0;
  int m_stalls = 0;
  bit m_tmo    = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_DIR_W   (RW),
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs_a          (id_rs_a),
    .id_rs_b          (id_rs_b),
    .id_use_a         (id_use_a),
    .id_use_b         (id_use_b),
    .exe_valid        (exe_valid),
    .exe_is_load      (exe_is_load),
    .exe_rd           (exe_rd),
    .exe_branch_taken (exe_branch_taken),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .hold_if_id       (hold_if_id),
    .hold_id_exe      (hold_id_exe),
    .hold_exe_mem     (hold_exe_mem),
    .hold_mem_wb      (hold_mem_wb),
    .flush_if_id      (flush_if_id),
    .flush_id_exe     (flush_id_exe),
    .mem_timeout      (mem_timeout),
    .stall_cycles     (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    rst = 1'b0; id_rs_a = '0; id_rs_b = '0; id_use_a = 1'b0; id_use_b = 1'b0;
    exe_valid = 1'b0; exe_is_load = 1'b0; exe_rd = '0; exe_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Is the pipe frozen by the memory this cycle, given current inputs?
  function automatic bit model_mem_stall();
    if (m_waited > 0) return !mem_ready && (m_waited < TMO);
    return mem_req && !mem_ready;
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance it.
  task automatic cycle(input string tag);
    logic [3:0] e_hold;
    logic [1:0] e_flush;
    bit         lu, stall;
    @(negedge clk);
    lu = exe_valid && exe_is_load &&
         ((id_use_a && id_rs_a == exe_rd) || (id_use_b && id_rs_b == exe_rd));
    stall = !rst && model_mem_stall();
    if (rst)                   begin e_hold = 4'b0000; e_flush = 2'b11; end
    else if (stall)            begin e_hold = 4'b1111; e_flush = 2'b00; end
    else if (exe_branch_taken) begin e_hold = 4'b0000; e_flush = 2'b11; end
    else if (lu)               begin e_hold = 4'b1000; e_flush = 2'b01; end
    else                       begin e_hold = 4'b0000; e_flush = 2'b00; end
    chk({tag, ".hold"}, 32'({hold_if_id, hold_id_exe, hold_exe_mem, hold_mem_wb}),
        32'(e_hold));
    chk({tag, ".flush"}, 32'({flush_if_id, flush_id_exe}), 32'(e_flush));
    chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
    chk({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_tmo));
    @(posedge clk);
    if (rst) begin
      m_waited = 0; m_stalls = 0; m_tmo = 1'b0;
    end else begin
      if (e_hold[3] && m_stalls < SAT) m_stalls++;
      if (stall) m_waited++;
      else begin
        if (m_waited > 0 && !mem_ready) m_tmo = 1'b1;
        m_waited = 0;
      end
    end
    #1;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    #1;
    // Reset behaviour.
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;
    cycle("idle");

    // Load-use on port A: one-cycle stall.
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'd5; id_rs_a = 4'd5; id_use_a = 1'b1;
    cycle("lu_a");
    idle_in();
    cycle("lu_after");
    chk("lu_cnt", 32'(stall_cycles), 32'd1);

    // Same addresses but source unused: no stall.
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'd5; id_rs_a = 4'd5; id_use_a = 1'b0;
    cycle("lu_unused");
    // Port B match with all-ones register address.
    id_rs_b = 4'hf; exe_rd = 4'hf; id_use_b = 1'b1;
    cycle("lu_b");
    // Branch outranks load-use.
    exe_rd = 4'd5; id_use_a = 1'b1; exe_branch_taken = 1'b1;
    cycle("br_lu");
    idle_in();

    // Memory ready on the third cycle after request.
    rst = 1'b1;
    cycle("rst2");
    idle_in();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cycle("mem3_wait");
    mem_ready = 1'b1;
    cycle("mem3_ready");
    idle_in();
    cycle("mem3_done");
    chk("mem3_cnt", 32'(stall_cycles), 32'd3);

    // Memory never ready: timeout after TMO held cycles, counter saturates.
    mem_req = 1'b1;
    for (int i = 0; i < TMO + 1; i++) cycle("tmo_wait");
    idle_in();
    cycle("tmo_after");
    chk("tmo_sticky", 32'(mem_timeout), 32'd1);
    chk("tmo_sat", 32'(stall_cycles), 32'(SAT));
    cycle("tmo_after2");

    // Reset in the middle of a memory wait.
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cycle("rstw_wait");
    rst = 1'b1;
    cycle("rstw_rst");
    idle_in();
    cycle("rstw_idle");
    chk("rstw_cnt", 32'(stall_cycles), 32'd0);

    // Random traffic; front-end inputs stay frozen while memory stalls.
    for (int n = 0; n < 600; n++) begin
      if (m_waited == 0) begin
        id_rs_a          = RW'($urandom_range(0, 3));
        id_rs_b          = RW'($urandom_range(0, 3));
        exe_rd           = RW'($urandom_range(0, 3));
        id_use_a         = ($urandom_range(0, 1) == 1);
        id_use_b         = ($urandom_range(0, 1) == 1);
        exe_valid        = ($urandom_range(0, 3) != 0);
        exe_is_load      = ($urandom_range(0, 1) == 1);
        exe_branch_taken = ($urandom_range(0, 6) == 0);
        mem_req          = ($urandom_range(0, 3) == 0);
      end
      mem_ready = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
